// File: rtl/cfi_lp_state_unit_pkg.sv
// Shared types and constants for the landing-pad CFI state unit.
// Operator encodings follow the LP operator field of the issue stage.
package cfi_lp_state_unit_pkg;

   localparam int unsigned XLEN    = 64;
   localparam int unsigned LP_LL_W = 9;
   localparam int unsigned LP_ML_W = 8;
   localparam int unsigned LP_UL_W = 8;

   localparam logic [11:0] CSR_LPLR = 12'h806;
   localparam logic [11:0] CSR_ELP  = 12'h807;

   typedef enum logic [2:0] {
      NONE  = 3'd0,
      LPSLL = 3'd1,
      LPSML = 3'd2,
      LPSUL = 3'd3,
      LPCLL = 3'd4
   } lp_op_t;

   typedef enum logic [1:0] {
      NO_LP       = 2'd0,
      LP_EXPECTED = 2'd1,
      FAULT       = 2'd2
   } elp_state_e;

   typedef struct packed {
      logic [LP_UL_W-1:0] ul;
      logic [LP_ML_W-1:0] ml;
      logic [LP_LL_W-1:0] ll;
   } lplr_t;

endpackage

// File: rtl/cfi_lp_state_unit_if.sv
// Commit port between the CSR buffer (master) and the LP state unit (slave).
interface cfi_lp_state_unit_if;
   import cfi_lp_state_unit_pkg::*;

   logic            commit_valid_i;
   lp_op_t          commit_op_i;
   logic [11:0]     csr_addr_i;
   logic [XLEN-1:0] csr_wdata_i;
   logic            commit_ack_o;

   modport master (
      output commit_valid_i, commit_op_i, csr_addr_i, csr_wdata_i,
      input  commit_ack_o
   );

   modport slave (
      input  commit_valid_i, commit_op_i, csr_addr_i, csr_wdata_i,
      output commit_ack_o
   );

endinterface

// File: rtl/cfi_lp_state_unit_label_cmp.sv
// Lower-label compare and fault tval formatting for the LP state unit.
// The tval path only exists when CFI_LP_TVAL_EN is defined.
module cfi_lp_label_cmp
   import cfi_lp_state_unit_pkg::*;
#(
   parameter int unsigned LL_W = LP_LL_W
) (
   input  logic [LL_W-1:0] i_exp_ll,
   input  logic [LL_W-1:0] i_rcv_ll,
   output logic            o_match
`ifdef CFI_LP_TVAL_EN
   ,
   input  logic            i_is_cll,
   output logic [XLEN-1:0] o_tval
`endif
);

   assign o_match = (i_exp_ll == i_rcv_ll);

`ifdef CFI_LP_TVAL_EN
   logic [LL_W-1:0] w_rcv;

   // A missing landing pad has no received label; report all-ones instead.
   assign w_rcv = i_is_cll ? i_rcv_ll : '1;

   always_comb begin
      o_tval              = '0;
      o_tval[2*LL_W-1:0]  = {i_exp_ll, w_rcv};
   end
`endif

endmodule

// File: rtl/cfi_lp_state_unit.sv
// Landing-pad CFI architectural state: LPLR, ELP state machine and fault request.
// Define CFI_LP_TVAL_EN to capture {expected LL, received label} into cfi_tval_o.
module cfi_lp_state_unit
   import cfi_lp_state_unit_pkg::*;
#(
   parameter int unsigned LL_W         = LP_LL_W,
   parameter int unsigned ML_W         = LP_ML_W,
   parameter int unsigned UL_W         = LP_UL_W,
   parameter logic        CFI_EN_RESET = 1'b1
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      flush_i,
   cfi_lp_state_unit_if.slave        commit_if,
   input  logic                      instr_commit_i,
   input  logic                      indirect_jump_i,
   input  logic [11:0]               csr_raddr_i,
   output logic [XLEN-1:0]           csr_rdata_o,
   output logic                      elp_init_o,
   output logic [LL_W+ML_W+UL_W-1:0] lplr_o,
   output logic                      cfi_fault_o,
   output logic [XLEN-1:0]           cfi_tval_o,
   input  logic                      fault_ack_i
);

   localparam int unsigned LPLR_W = LL_W + ML_W + UL_W;

   elp_state_e      r_state, w_state_nxt;
   logic [LL_W-1:0] r_ll;
   logic [ML_W-1:0] r_ml;
   logic [UL_W-1:0] r_ul;
   logic            r_en;

   logic            w_fire;
   logic            w_cll;
   logic            w_lplr_wr;
   logic            w_elp_wr;
   logic            w_match;
   logic            w_unused;

   // Ops arriving during FAULT stay in the CSR buffer until the flush.
   assign commit_if.commit_ack_o = commit_if.commit_valid_i & (r_state != FAULT) & ~flush_i;

   assign w_fire    = commit_if.commit_valid_i & commit_if.commit_ack_o;
   assign w_cll     = w_fire & (commit_if.commit_op_i == LPCLL);
   assign w_lplr_wr = w_fire & (commit_if.commit_op_i == NONE) & (commit_if.csr_addr_i == CSR_LPLR);
   assign w_elp_wr  = w_fire & (commit_if.commit_op_i == NONE) & (commit_if.csr_addr_i == CSR_ELP);
   assign w_unused  = ^commit_if.csr_wdata_i[XLEN-1:LPLR_W];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_ll <= '0;
         r_ml <= '0;
         r_ul <= '0;
      end else if (w_lplr_wr) begin
         {r_ul, r_ml, r_ll} <= commit_if.csr_wdata_i[LPLR_W-1:0];
      end else if (w_fire) begin
         case (commit_if.commit_op_i)
            LPSLL:   r_ll <= commit_if.csr_wdata_i[LL_W-1:0];
            LPSML:   r_ml <= commit_if.csr_wdata_i[ML_W-1:0];
            LPSUL:   r_ul <= commit_if.csr_wdata_i[UL_W-1:0];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)       r_en <= CFI_EN_RESET;
      else if (w_elp_wr) r_en <= commit_if.csr_wdata_i[1];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= NO_LP;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         NO_LP: begin
            if (instr_commit_i & indirect_jump_i & r_en) w_state_nxt = LP_EXPECTED;
         end
         LP_EXPECTED: begin
            if (!r_en)               w_state_nxt = NO_LP;
            else if (w_cll)          w_state_nxt = w_match ? NO_LP : FAULT;
            else if (instr_commit_i) w_state_nxt = FAULT;
         end
         FAULT: begin
            // A jump retiring alongside the ack is squashed by the exception.
            if (fault_ack_i) w_state_nxt = NO_LP;
         end
         default: w_state_nxt = NO_LP;
      endcase
      // An explicit ELP write overrides any implicit transition this cycle.
      if (w_elp_wr) w_state_nxt = commit_if.csr_wdata_i[0] ? LP_EXPECTED : NO_LP;
   end

`ifdef CFI_LP_TVAL_EN
   logic [XLEN-1:0] w_tval;
   logic [XLEN-1:0] r_tval;

   cfi_lp_label_cmp #(.LL_W(LL_W)) u_label_cmp (
      .i_exp_ll (r_ll),
      .i_rcv_ll (commit_if.csr_wdata_i[LL_W-1:0]),
      .o_match  (w_match),
      .i_is_cll (w_cll),
      .o_tval   (w_tval)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                                       r_tval <= '0;
      else if ((r_state != FAULT) && (w_state_nxt == FAULT)) r_tval <= w_tval;
   end

   assign cfi_tval_o = r_tval;
`else
   cfi_lp_label_cmp #(.LL_W(LL_W)) u_label_cmp (
      .i_exp_ll (r_ll),
      .i_rcv_ll (commit_if.csr_wdata_i[LL_W-1:0]),
      .o_match  (w_match)
   );

   assign cfi_tval_o = '0;
`endif

   always_comb begin
      csr_rdata_o = '0;
      if (csr_raddr_i == CSR_LPLR)     csr_rdata_o[LPLR_W-1:0] = {r_ul, r_ml, r_ll};
      else if (csr_raddr_i == CSR_ELP) csr_rdata_o[1:0]        = {r_en, r_state == LP_EXPECTED};
   end

   assign elp_init_o  = (r_state == LP_EXPECTED);
   assign cfi_fault_o = (r_state == FAULT);
   assign lplr_o      = {r_ul, r_ml, r_ll};

endmodule

// File: tb/tb_cfi_lp_state_unit.sv
// Vector table plus scoreboard bench for cfi_lp_state_unit, with hand-written
// sequences for async reset and flush during FAULT.
module tb_cfi_lp_state_unit;
   import cfi_lp_state_unit_pkg::*;

   typedef struct {
      string       name;
      logic        vld;
      lp_op_t      op;
      logic [11:0] addr;
      logic [63:0] wd;
      logic        ic, ij, fl, fa;
      logic [11:0] ra;
      logic        e_ack, e_elp, e_flt;
      logic [24:0] e_lplr;
      logic [63:0] e_rd;
      logic [63:0] e_tv;
   } vec_t;

   logic            clk = 1'b0;
   logic            rst_ni;
   logic            flush_i, instr_commit_i, indirect_jump_i, fault_ack_i;
   logic [11:0]     csr_raddr_i;
   logic [63:0]     csr_rdata_o, cfi_tval_o;
   logic            elp_init_o, cfi_fault_o;
   logic [24:0]     lplr_o;

   int n_chk = 0;
   int n_err = 0;

   vec_t vecs[$];
   vec_t sb[$];
   vec_t v, e;

   cfi_lp_state_unit_if cif ();

   cfi_lp_state_unit dut (
      .clk_i           (clk),
      .rst_ni          (rst_ni),
      .flush_i         (flush_i),
      .commit_if       (cif),
      .instr_commit_i  (instr_commit_i),
      .indirect_jump_i (indirect_jump_i),
      .csr_raddr_i     (csr_raddr_i),
      .csr_rdata_o     (csr_rdata_o),
      .elp_init_o      (elp_init_o),
      .lplr_o          (lplr_o),
      .cfi_fault_o     (cfi_fault_o),
      .cfi_tval_o      (cfi_tval_o),
      .fault_ack_i     (fault_ack_i)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] tv_exp(input logic [63:0] tv);
`ifdef CFI_LP_TVAL_EN
      return tv;
`else
      return (tv & 64'h0);
`endif
   endfunction

   function automatic vec_t mk(input string nm, input logic vld, input lp_op_t op,
                               input logic [11:0] addr, input logic [63:0] wd,
                               input logic ic, input logic ij, input logic fl, input logic fa,
                               input logic [11:0] ra, input logic e_ack, input logic e_elp,
                               input logic e_flt, input logic [24:0] e_lplr,
                               input logic [63:0] e_rd, input logic [63:0] e_tv);
      vec_t r;
      r.name = nm; r.vld = vld; r.op = op; r.addr = addr; r.wd = wd;
      r.ic = ic; r.ij = ij; r.fl = fl; r.fa = fa; r.ra = ra;
      r.e_ack = e_ack; r.e_elp = e_elp; r.e_flt = e_flt;
      r.e_lplr = e_lplr; r.e_rd = e_rd; r.e_tv = e_tv;
      return r;
   endfunction

   task automatic drive_idle();
      cif.commit_valid_i = 1'b0;
      cif.commit_op_i    = NONE;
      cif.csr_addr_i     = 12'h0;
      cif.csr_wdata_i    = 64'h0;
      flush_i            = 1'b0;
      instr_commit_i     = 1'b0;
      indirect_jump_i    = 1'b0;
      fault_ack_i        = 1'b0;
   endtask

   initial begin
      rst_ni      = 1'b0;
      csr_raddr_i = CSR_ELP;
      drive_idle();

      // LPLR packs as {UL[24:17], ML[16:9], LL[8:0]}; tval as {LL, received}.
      //                  name          vld op     addr      wdata                  ic ij fl fa ra        ack elp flt lplr         rdata        tval
      vecs.push_back(mk("lpsll",        1, LPSLL, 12'h000, 64'h1A5,                0, 0, 0, 0, CSR_LPLR, 1, 0, 0, 25'h00001A5, 64'h1A5,     64'h0));
      vecs.push_back(mk("lpsml",        1, LPSML, 12'h000, 64'h3C,                 0, 0, 0, 0, CSR_LPLR, 1, 0, 0, 25'h00079A5, 64'h79A5,    64'h0));
      vecs.push_back(mk("lpsul",        1, LPSUL, 12'h000, 64'h7F,                 0, 0, 0, 0, CSR_LPLR, 1, 0, 0, 25'h0FE79A5, 64'hFE79A5,  64'h0));
      vecs.push_back(mk("ijump",        0, NONE,  12'h000, 64'h0,                  1, 1, 0, 0, CSR_ELP,  0, 1, 0, 25'h0FE79A5, 64'h3,       64'h0));
      vecs.push_back(mk("lpcll_ok",     1, LPCLL, 12'h000, 64'h1A5,                1, 0, 0, 0, CSR_ELP,  1, 0, 0, 25'h0FE79A5, 64'h2,       64'h0));
      vecs.push_back(mk("ijump2",       0, NONE,  12'h000, 64'h0,                  1, 1, 0, 0, CSR_ELP,  0, 1, 0, 25'h0FE79A5, 64'h3,       64'h0));
      vecs.push_back(mk("lpcll_bad",    1, LPCLL, 12'h000, 64'h1A4,                1, 0, 0, 0, CSR_ELP,  1, 0, 1, 25'h0FE79A5, 64'h2,       64'h34BA4));
      vecs.push_back(mk("fault_drop",   1, LPSLL, 12'h000, 64'h055,                1, 0, 0, 0, CSR_LPLR, 0, 0, 1, 25'h0FE79A5, 64'hFE79A5,  64'h34BA4));
      vecs.push_back(mk("fault_ack",    0, NONE,  12'h000, 64'h0,                  0, 0, 0, 1, CSR_ELP,  0, 0, 0, 25'h0FE79A5, 64'h2,       64'h34BA4));
      vecs.push_back(mk("ijump3",       0, NONE,  12'h000, 64'h0,                  1, 1, 0, 0, CSR_ELP,  0, 1, 0, 25'h0FE79A5, 64'h3,       64'h34BA4));
      vecs.push_back(mk("add_retire",   0, NONE,  12'h000, 64'h0,                  1, 0, 0, 0, CSR_ELP,  0, 0, 1, 25'h0FE79A5, 64'h2,       64'h34BFF));
      vecs.push_back(mk("ack_blocked",  1, NONE,  CSR_ELP, 64'h0,                  1, 0, 0, 0, CSR_ELP,  0, 0, 1, 25'h0FE79A5, 64'h2,       64'h34BFF));
      vecs.push_back(mk("ack_with_jmp", 0, NONE,  12'h000, 64'h0,                  1, 1, 0, 1, CSR_ELP,  0, 0, 0, 25'h0FE79A5, 64'h2,       64'h34BFF));
      vecs.push_back(mk("elp_dis",      1, NONE,  CSR_ELP, 64'h0,                  1, 0, 0, 0, CSR_ELP,  1, 0, 0, 25'h0FE79A5, 64'h0,       64'h34BFF));
      vecs.push_back(mk("ijump_dis",    0, NONE,  12'h000, 64'h0,                  1, 1, 0, 0, CSR_ELP,  0, 0, 0, 25'h0FE79A5, 64'h0,       64'h34BFF));
      vecs.push_back(mk("elp_wr3",      1, NONE,  CSR_ELP, 64'h3,                  1, 0, 0, 0, CSR_ELP,  1, 1, 0, 25'h0FE79A5, 64'h3,       64'h34BFF));
      vecs.push_back(mk("flush_exp",    1, LPSLL, 12'h000, 64'h0AA,                0, 0, 1, 0, CSR_LPLR, 0, 1, 0, 25'h0FE79A5, 64'hFE79A5,  64'h34BFF));
      vecs.push_back(mk("lpcll_ok2",    1, LPCLL, 12'h000, 64'h1A5,                1, 0, 0, 0, CSR_ELP,  1, 0, 0, 25'h0FE79A5, 64'h2,       64'h34BFF));
      vecs.push_back(mk("lplr_wr",      1, NONE,  CSR_LPLR, 64'hFFFF_0000_0123_4567, 1, 0, 0, 0, CSR_LPLR, 1, 0, 0, 25'h1234567, 64'h1234567, 64'h34BFF));
      vecs.push_back(mk("other_addr",   1, NONE,  12'h300, 64'hFFFF,               1, 0, 0, 0, 12'h300,  1, 0, 0, 25'h1234567, 64'h0,       64'h34BFF));
      vecs.push_back(mk("elp_wr_jump",  1, NONE,  CSR_ELP, 64'h2,                  1, 1, 0, 0, CSR_ELP,  1, 0, 0, 25'h1234567, 64'h2,       64'h34BFF));
      vecs.push_back(mk("elp_wr_en0",   1, NONE,  CSR_ELP, 64'h1,                  1, 0, 0, 0, CSR_ELP,  1, 1, 0, 25'h1234567, 64'h1,       64'h34BFF));
      vecs.push_back(mk("en0_force",    0, NONE,  12'h000, 64'h0,                  0, 0, 0, 0, CSR_ELP,  0, 0, 0, 25'h1234567, 64'h0,       64'h34BFF));
      vecs.push_back(mk("elp_wr_en1",   1, NONE,  CSR_ELP, 64'h2,                  1, 0, 0, 0, CSR_ELP,  1, 0, 0, 25'h1234567, 64'h2,       64'h34BFF));

      // Reset state, checked before any clock edge releases anything.
      #12;
      chk("rst.fault", cfi_fault_o, 1'b0);
      chk("rst.elp",   elp_init_o, 1'b0);
      chk("rst.lplr",  lplr_o, 25'h0);
      chk("rst.tval",  cfi_tval_o, 64'h0);
      chk("rst.ack",   cif.commit_ack_o, 1'b0);
      chk("rst.rd_elp", csr_rdata_o, 64'h2);
      @(negedge clk);
      rst_ni = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         @(negedge clk);
         cif.commit_valid_i = v.vld;
         cif.commit_op_i    = v.op;
         cif.csr_addr_i     = v.addr;
         cif.csr_wdata_i    = v.wd;
         instr_commit_i     = v.ic;
         indirect_jump_i    = v.ij;
         flush_i            = v.fl;
         fault_ack_i        = v.fa;
         csr_raddr_i        = v.ra;
         #1;
         chk({v.name, ".ack"}, cif.commit_ack_o, v.e_ack);
         sb.push_back(v);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         chk({e.name, ".elp"},   elp_init_o,  e.e_elp);
         chk({e.name, ".fault"}, cfi_fault_o, e.e_flt);
         chk({e.name, ".lplr"},  lplr_o,      e.e_lplr);
         chk({e.name, ".rdata"}, csr_rdata_o, e.e_rd);
         chk({e.name, ".tval"},  cfi_tval_o,  tv_exp(e.e_tv));
      end

      // Enter FAULT through a missing landing pad with LL = 0x167.
      @(negedge clk);
      drive_idle();
      instr_commit_i  = 1'b1;
      indirect_jump_i = 1'b1;
      @(negedge clk);
      indirect_jump_i = 1'b0;
      @(negedge clk);
      drive_idle();
      chk("seq.fault_entry", cfi_fault_o, 1'b1);
      chk("seq.tval_entry",  cfi_tval_o, tv_exp(64'h2CFFF));

      // Flush never clears FAULT.
      flush_i            = 1'b1;
      cif.commit_valid_i = 1'b1;
      #1;
      chk("seq.flush_ack", cif.commit_ack_o, 1'b0);
      @(negedge clk);
      drive_idle();
      chk("seq.flush_fault", cfi_fault_o, 1'b1);

      // Async reset in mid-cycle, no clock edge in between.
      csr_raddr_i = CSR_ELP;
      #2;
      rst_ni = 1'b0;
      #1;
      chk("arst.fault", cfi_fault_o, 1'b0);
      chk("arst.elp",   elp_init_o, 1'b0);
      chk("arst.lplr",  lplr_o, 25'h0);
      chk("arst.tval",  cfi_tval_o, 64'h0);
      chk("arst.ack",   cif.commit_ack_o, 1'b0);
      chk("arst.rd_elp", csr_rdata_o, 64'h2);
      @(negedge clk);
      rst_ni = 1'b1;
      @(negedge clk);
      chk("arst.sb_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/cfi_lp_state_unit.md
Name: cfi_lp_state_unit

Overview:
- Architectural state holder for landing-pad CFI, sitting at commit next to the CSR file.
- Consumes CSR-buffer commits: committed address plus operand data, tagged with the LP operator.
- Holds the landing-pad label register (LPLR) and the expected-landing-pad (ELP) state machine.
- Raises CFI faults and drives elp_init_o back upstream into the CSR buffer so it retargets the pending CSR address to CSR_ELP.

Parameters:
- LL_W, 9: lower-label field width.
- ML_W, 8: middle-label field width.
- UL_W, 8: upper-label field width.
- CFI_EN_RESET, 1'b1: reset value of the CFI enable bit.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous reset, active low.
- flush_i  in  1  pipeline flush.
- commit_valid_i  in  1  CSR/LP op committing this cycle.
- commit_op_i  in  lp_op_t  NONE/LPSLL/LPSML/LPSUL/LPCLL.
- csr_addr_i  in  12  committed CSR address.
- csr_wdata_i  in  XLEN  committed operand/result.
- instr_commit_i  in  1  any instruction retiring this cycle.
- indirect_jump_i  in  1  the retiring instruction is an indirect jump/call.
- commit_ack_o  out  1  op accepted (commit-pulse to CSR buffer).
- csr_raddr_i  in  12  read address.
- csr_rdata_o  out  XLEN  read data.
- elp_init_o  out  1  ELP is LP_EXPECTED; goes upstream.
- lplr_o  out  LL_W+ML_W+UL_W  current LPLR, packed {UL,ML,LL}.
- cfi_fault_o  out  1  CFI exception request.
- cfi_tval_o  out  XLEN  fault tval.
- fault_ack_i  in  1  exception taken.

Behaviour:
- Reset values:
  - LPLR = 0, ELP state = NO_LP, enable = CFI_EN_RESET.
  - cfi_fault_o = 0, cfi_tval_o = 0, commit_ack_o = 0, elp_init_o = 0.
- Registered outputs: every state update is visible the cycle after the commit; csr_rdata_o is combinational from current state.
- commit_ack_o:
  - equals commit_valid_i, except forced 0 while state = FAULT.
  - Ops presented during FAULT are dropped; the CSR buffer holds them until flush.
- Label ops (only when commit_valid_i & ack):
  - LPSLL: LL = wdata[LL_W-1:0].
  - LPSML: ML = wdata[ML_W-1:0].
  - LPSUL: UL = wdata[UL_W-1:0].
  - LPCLL: compare wdata[LL_W-1:0] against LL.
  - NONE with csr_addr_i == CSR_LPLR: LPLR = wdata packed field-wise.
  - NONE with csr_addr_i == CSR_ELP: state = wdata[0] ? LP_EXPECTED : NO_LP; enable = wdata[1].
  - Any other address: ignored (owned by the CSR file).
- Read mux:
  - CSR_LPLR returns zero-extended LPLR.
  - CSR_ELP returns {enable, state==LP_EXPECTED}.
  - All other addresses return 0.
- ELP FSM, states NO_LP, LP_EXPECTED, FAULT:
  - NO_LP -> LP_EXPECTED: instr_commit_i & indirect_jump_i & enable.
  - LP_EXPECTED -> NO_LP: LPCLL commits with label match.
  - LP_EXPECTED -> FAULT: LPCLL mismatch, or instr_commit_i with anything other than LPCLL.
  - FAULT -> NO_LP: fault_ack_i.
  - enable = 0 forces NO_LP from LP_EXPECTED next cycle; FAULT is unaffected.
- elp_init_o = (state == LP_EXPECTED).
- Fault outputs: cfi_fault_o = (state == FAULT), held high until fault_ack_i.
- Simultaneous events:
  - Label write plus LPCLL in the same cycle cannot occur (single commit port).
  - ELP write with an indirect jump: the CSR write wins.
  - flush_i does not alter architectural state or clear FAULT (committed effects are final); it only zeroes commit_ack_o that cycle.
  - fault_ack_i with a new indirect jump: ends in NO_LP; the jump is squashed by the exception.
- Async reset mid-operation returns all state to reset values immediately.

Optional Feature:
- Macro CFI_LP_TVAL_EN.
  - Defined: on entering FAULT, cfi_tval_o latches {expected LL, received label} zero-extended; for a non-LPCLL commit the received label is all-ones.
  - Undefined: cfi_tval_o is constant 0 and the capture register is removed.

Decomposition:
- Package ariane_pkg:
  - lp_op_t, reusing operator encodings.
  - elp_state_e.
  - lplr_t packed struct {ul, ml, ll}.
  - Width constants.
- Package riscv: CSR_LPLR and CSR_ELP addresses.
- One natural sub-module: cfi_lp_label_cmp, combinational compare plus tval formatting.

Test Plan:
- Labels and readback: LPSLL 0x1A5, LPSML 0x3C, LPSUL 0x7F -> lplr_o = {0x7F,0x3C,0x1A5}; CSR_LPLR readback matches.
- Matching landing pad: indirect jump retire -> elp_init_o=1 next cycle; LPCLL 0x1A5 -> NO_LP, no fault.
- Label mismatch: LP_EXPECTED, LPCLL 0x1A4 -> cfi_fault_o=1, held; with CFI_LP_TVAL_EN, tval = {0x1A5,0x1A4}; fault_ack_i -> NO_LP, fault 0.
- Missing landing pad: LP_EXPECTED then ordinary ADD retires -> FAULT; subsequent commit_valid_i gets commit_ack_o=0.
- Disabled CFI: CSR_ELP write 0x0, then indirect jump -> state stays NO_LP; write 0x3 -> LP_EXPECTED, enable readback 1.
- Reset and flush: assert rst_ni low during FAULT -> all outputs 0 asynchronously; flush_i during LP_EXPECTED -> state unchanged.
